hazard_detection_unit: RTL and testbench
========================================

# hazard_detection_unit

Pipeline control block for the five-stage MIPS datapath, complementary to the forwarding unit: where forwarding resolves RAW hazards by routing results forward, this block resolves what forwarding cannot by holding the front of the pipe back. It detects load-use hazards and inserts one bubble. It flushes IF/ID on taken branches and jumps resolved in ID. It drains the pipeline after a HALT and holds the core halted, keeping saturating stall and flush counters for the debug unit.

## Interface
- N_BITS_REG, 5, register-index width
- DRAIN_CYCLES, 3, enabled cycles between HALT acceptance in ID and its retirement from WB
- CNT_BITS, 16, width of statistics counters
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  debug step enable; 0 freezes FSM and counters
- i_rs_IF_ID  in  N_BITS_REG  rs of the instruction in ID
- i_rt_IF_ID  in  N_BITS_REG  rt of the instruction in ID
- i_rt_ID_EX  in  N_BITS_REG  destination rt of the instruction in EX
- i_memRead_ID_EX  in  1  instruction in EX is a load
- i_branch_taken  in  1  branch in ID resolved taken
- i_jump  in  1  J/JAL/JR/JALR in ID
- i_halt_ID  in  1  HALT decoded in ID
- o_pc_write  out  1  PC load enable
- o_if_id_write  out  1  IF/ID load enable
- o_if_id_flush  out  1  IF/ID loads a NOP
- o_id_ex_bubble  out  1  ID/EX control fields zeroed
- o_halted  out  1  core halted
- o_stall_cnt  out  CNT_BITS  load-use stall cycles, saturating
- o_flush_cnt  out  CNT_BITS  branch/jump flush cycles, saturating

## Operation
- hazard = i_memRead_ID_EX && i_rt_ID_EX != 0 && (i_rt_ID_EX == i_rs_IF_ID || i_rt_ID_EX == i_rt_IF_ID).
- FSM states: RUN, DRAIN, HALTED. Outputs are Mealy, decoded from state and inputs.
- RUN, priority from highest to lowest:
  - hazard: pc_write=0, if_id_write=0, bubble=1, flush=0. Branch, jump and HALT are ignored this cycle and re-evaluate next cycle.
  - i_halt_ID: pc_write=0, if_id_write=1, flush=1. Next state DRAIN; drain counter loaded with DRAIN_CYCLES.
  - i_branch_taken or i_jump: pc_write=1, if_id_write=1, flush=1.
  - else: pc_write=1, if_id_write=1, flush=0, bubble=0.
- DRAIN: pc_write=0, if_id_write=1, flush=1, bubble=0, so NOPs are fed behind the HALT. Drain counter decrements per enabled cycle; at counter==1, next state HALTED. Hazard, branch and halt inputs are ignored.
- HALTED: all enables and flush are 0, o_halted=1. Remains until reset.
- i_enable=0: state, drain counter and stats counters hold. o_pc_write, o_if_id_write, o_if_id_flush and o_id_ex_bubble are all 0; o_halted still reflects state.
- Counters:
  - o_stall_cnt increments on enabled RUN cycles with hazard.
  - o_flush_cnt increments on enabled RUN cycles with branch or jump flush, excluding hazard cycles and HALT flushes.
  - Both saturate at 2^CNT_BITS-1; no wrap.

## Timing
- Reset (i_reset high at an edge): state RUN, drain counter 0, both statistics counters 0.
- While i_reset is high, all four control outputs and o_halted are forced to 0.
- First cycle after reset: o_pc_write=1, o_if_id_write=1.
- Stall, bubble and flush are combinational in the same cycle as the triggering inputs: zero latency.
- A load-use hazard yields exactly one stall cycle, because the load moves to MEM and the hazard deasserts.
- HALT accepted in ID at cycle t:
  - DRAIN during enabled cycles t+1..t+DRAIN_CYCLES.
  - o_halted=1 from t+DRAIN_CYCLES+1.
  - Disabled cycles stretch the window without changing its count.
- Counter updates are visible the cycle after the event.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge.

## Structure
- Shared package (hdu_pkg):
  - state encoding: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2
  - defaults for N_BITS_REG, DRAIN_CYCLES and CNT_BITS
- Sub-module sat_counter (parameter width; ports clock, reset, increment enable, count), instantiated twice for the statistics counters.
- The drain counter is width $clog2(DRAIN_CYCLES+1), internal to the FSM.

## Test plan
- Load-use: memRead=1, rt_ID_EX=5, rs_IF_ID=5 for 1 cycle -> pc_write=0, if_id_write=0, bubble=1 that cycle; o_stall_cnt=1 next cycle.
- Same stimulus with rt_ID_EX=0 -> no stall; stall count stays 0.
- Branch taken in RUN with no hazard -> flush=1, pc_write=1; o_flush_cnt=1. Branch simultaneous with hazard -> stall only, flush=0, o_flush_cnt unchanged.
- HALT at cycle t with DRAIN_CYCLES=3 -> flush=1 at t, DRAIN t+1..t+3, o_halted=1 at t+4 and held for 10 further cycles with all enables 0.
- i_enable=0 for 2 cycles mid-DRAIN -> counter frozen and outputs 0; o_halted asserts 2 cycles later than in the previous scenario. Reset in HALTED -> o_halted=0 and RUN restored one edge later.
- Saturation with CNT_BITS=4: 20 hazard cycles -> o_stall_cnt=15, no wrap.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// hdu_pkg: shared definitions for the hazard detection unit.
//   - FSM state encoding (RUN / DRAIN / HALTED)
//   - default values for register-index width, drain length and
//     statistics counter width
package hdu_pkg;

   localparam int unsigned HDU_N_BITS_REG   = 5;
   localparam int unsigned HDU_DRAIN_CYCLES = 3;
   localparam int unsigned HDU_CNT_BITS     = 16;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hdu_state_e;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: pipeline <-> hazard unit signal bundle.
//   Inputs to the unit : i_enable, ID/EX register indices, i_memRead_ID_EX,
//                        i_branch_taken, i_jump, i_halt_ID
//   Outputs of the unit: PC / IF-ID enables, IF-ID flush, ID-EX bubble,
//                        halted flag, stall and flush statistics
//   modport master : pipeline/debug side (drives i_*, reads o_*)
//   modport slave  : hazard unit side (reads i_*, drives o_*)
interface hazard_detection_unit_if
   import hdu_pkg::*;
#(
   parameter int unsigned N_BITS_REG = HDU_N_BITS_REG,
   parameter int unsigned CNT_BITS   = HDU_CNT_BITS
);

   logic                  i_enable;
   logic [N_BITS_REG-1:0] i_rs_IF_ID;
   logic [N_BITS_REG-1:0] i_rt_IF_ID;
   logic [N_BITS_REG-1:0] i_rt_ID_EX;
   logic                  i_memRead_ID_EX;
   logic                  i_branch_taken;
   logic                  i_jump;
   logic                  i_halt_ID;

   logic                  o_pc_write;
   logic                  o_if_id_write;
   logic                  o_if_id_flush;
   logic                  o_id_ex_bubble;
   logic                  o_halted;
   logic [CNT_BITS-1:0]   o_stall_cnt;
   logic [CNT_BITS-1:0]   o_flush_cnt;

   modport master (
      output i_enable, i_rs_IF_ID, i_rt_IF_ID, i_rt_ID_EX,
             i_memRead_ID_EX, i_branch_taken, i_jump, i_halt_ID,
      input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
             o_halted, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_enable, i_rs_IF_ID, i_rt_IF_ID, i_rt_ID_EX,
             i_memRead_ID_EX, i_branch_taken, i_jump, i_halt_ID,
      output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
             o_halted, o_stall_cnt, o_flush_cnt
   );

endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high clear
//   i_inc   : count one event this cycle
//   o_count : current count
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         o_count <= '0;
      else if (i_inc && (o_count != '1))
         o_count <= o_count + WIDTH'(1);
   end

endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use stall, branch/jump flush and HALT drain
// control for the five-stage pipeline.
//   i_clk, i_reset : clock and synchronous active-high reset
//   hdu_bus        : slave side of hazard_detection_unit_if
//     control outputs are combinational from state and inputs (zero latency);
//     o_stall_cnt / o_flush_cnt are saturating event counters.
module hazard_detection_unit
   import hdu_pkg::*;
#(
   parameter int unsigned N_BITS_REG   = HDU_N_BITS_REG,
   parameter int unsigned DRAIN_CYCLES = HDU_DRAIN_CYCLES,
   parameter int unsigned CNT_BITS     = HDU_CNT_BITS
) (
   input logic                     i_clk,
   input logic                     i_reset,
   hazard_detection_unit_if.slave  hdu_bus
);

   localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

   hdu_state_e            state;
   logic [DW-1:0]         drain_cnt;

   logic [N_BITS_REG-1:0] rs_id;
   logic [N_BITS_REG-1:0] rt_id;
   logic [N_BITS_REG-1:0] rt_ex;
   logic                  hazard;
   logic                  enable;
   logic                  stall_inc;
   logic                  flush_inc;
   logic [CNT_BITS-1:0]   stall_cnt;
   logic [CNT_BITS-1:0]   flush_cnt;

   assign rs_id  = hdu_bus.i_rs_IF_ID;
   assign rt_id  = hdu_bus.i_rt_IF_ID;
   assign rt_ex  = hdu_bus.i_rt_ID_EX;
   assign enable = hdu_bus.i_enable;

   // $zero is never a real destination, so a load into r0 cannot hazard.
   assign hazard = hdu_bus.i_memRead_ID_EX && (rt_ex != '0) &&
                   ((rt_ex == rs_id) || (rt_ex == rt_id));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= RUN;
         drain_cnt <= '0;
      end else if (enable) begin
         case (state)
            RUN: begin
               if (!hazard && hdu_bus.i_halt_ID) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_INIT;
               end
            end
            DRAIN: begin
               if (drain_cnt == DW'(1))
                  state <= HALTED;
               drain_cnt <= drain_cnt - DW'(1);
            end
            HALTED: ;
            default: state <= RUN;
         endcase
      end
   end

   always_comb begin
      hdu_bus.o_pc_write     = 1'b0;
      hdu_bus.o_if_id_write  = 1'b0;
      hdu_bus.o_if_id_flush  = 1'b0;
      hdu_bus.o_id_ex_bubble = 1'b0;
      if (!i_reset && enable) begin
         case (state)
            RUN: begin
               if (hazard) begin
                  hdu_bus.o_id_ex_bubble = 1'b1;
               end else if (hdu_bus.i_halt_ID) begin
                  hdu_bus.o_if_id_write = 1'b1;
                  hdu_bus.o_if_id_flush = 1'b1;
               end else begin
                  hdu_bus.o_pc_write    = 1'b1;
                  hdu_bus.o_if_id_write = 1'b1;
                  hdu_bus.o_if_id_flush = hdu_bus.i_branch_taken || hdu_bus.i_jump;
               end
            end
            DRAIN: begin
               hdu_bus.o_if_id_write = 1'b1;
               hdu_bus.o_if_id_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hdu_bus.o_halted = !i_reset && (state == HALTED);

   // HALT flushes and hazard cycles are not counted as branch/jump flushes.
   assign stall_inc = enable && (state == RUN) && hazard;
   assign flush_inc = enable && (state == RUN) && !hazard && !hdu_bus.i_halt_ID &&
                      (hdu_bus.i_branch_taken || hdu_bus.i_jump);

   sat_counter #(.WIDTH(CNT_BITS)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (stall_inc),
      .o_count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_BITS)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (flush_inc),
      .o_count (flush_cnt)
   );

   assign hdu_bus.o_stall_cnt = stall_cnt;
   assign hdu_bus.o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
`timescale 1ns/1ps

module tb_hazard_detection_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hazard_detection_unit_if #(.N_BITS_REG(5), .CNT_BITS(4)) hif ();

  hazard_detection_unit #(
    .N_BITS_REG   (5),
    .DRAIN_CYCLES (3),
    .CNT_BITS     (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .hdu_bus (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input string tag, input logic pc, input logic ifid,
                      input logic fl, input logic bub, input logic hlt);
    chk({tag, ".pc_write"},    hif.o_pc_write,     pc);
    chk({tag, ".if_id_write"}, hif.o_if_id_write,  ifid);
    chk({tag, ".flush"},       hif.o_if_id_flush,  fl);
    chk({tag, ".bubble"},      hif.o_id_ex_bubble, bub);
    chk({tag, ".halted"},      hif.o_halted,       hlt);
  endtask

  task automatic clear_inputs();
    hif.i_enable        = 1'b1;
    hif.i_rs_IF_ID      = '0;
    hif.i_rt_IF_ID      = '0;
    hif.i_rt_ID_EX      = '0;
    hif.i_memRead_ID_EX = 1'b0;
    hif.i_branch_taken  = 1'b0;
    hif.i_jump          = 1'b0;
    hif.i_halt_ID       = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clear_inputs();

    sample(); ctrl("reset", 0, 0, 0, 0, 0);
    tick(); rst = 1'b0;
    sample(); ctrl("post_reset", 1, 1, 0, 0, 0);
    chk("post_reset.stall_cnt", hif.o_stall_cnt, 4'd0);
    chk("post_reset.flush_cnt", hif.o_flush_cnt, 4'd0);

    tick(); hif.i_memRead_ID_EX = 1'b1; hif.i_rt_ID_EX = 5'd5; hif.i_rs_IF_ID = 5'd5;
    sample(); ctrl("loaduse_rs", 0, 0, 0, 1, 0);
    tick(); hif.i_memRead_ID_EX = 1'b0;
    sample(); ctrl("after_loaduse", 1, 1, 0, 0, 0);
    chk("after_loaduse.stall_cnt", hif.o_stall_cnt, 4'd1);

    tick(); hif.i_memRead_ID_EX = 1'b1; hif.i_rt_ID_EX = 5'd7;
    hif.i_rs_IF_ID = 5'd3; hif.i_rt_IF_ID = 5'd7;
    sample(); ctrl("loaduse_rt", 0, 0, 0, 1, 0);
    tick(); hif.i_memRead_ID_EX = 1'b0;
    sample(); chk("loaduse_rt.stall_cnt", hif.o_stall_cnt, 4'd2);

    tick(); hif.i_memRead_ID_EX = 1'b1; hif.i_rt_ID_EX = 5'd0;
    hif.i_rs_IF_ID = 5'd0; hif.i_rt_IF_ID = 5'd0;
    sample(); ctrl("load_r0", 1, 1, 0, 0, 0);
    tick(); hif.i_rt_ID_EX = 5'd5; hif.i_rs_IF_ID = 5'd6; hif.i_rt_IF_ID = 5'd7;
    sample(); chk("load_r0.stall_cnt", hif.o_stall_cnt, 4'd2);
    ctrl("load_nomatch", 1, 1, 0, 0, 0);

    tick(); hif.i_memRead_ID_EX = 1'b0; hif.i_branch_taken = 1'b1;
    sample(); ctrl("branch", 1, 1, 1, 0, 0);
    tick(); hif.i_branch_taken = 1'b0; hif.i_jump = 1'b1;
    sample(); ctrl("jump", 1, 1, 1, 0, 0);
    chk("branch.flush_cnt", hif.o_flush_cnt, 4'd1);

    tick(); hif.i_jump = 1'b0; hif.i_branch_taken = 1'b1;
    hif.i_memRead_ID_EX = 1'b1; hif.i_rt_ID_EX = 5'd6; hif.i_rs_IF_ID = 5'd6;
    sample(); ctrl("branch_hazard", 0, 0, 0, 1, 0);
    chk("jump.flush_cnt", hif.o_flush_cnt, 4'd2);
    tick(); hif.i_branch_taken = 1'b0; hif.i_halt_ID = 1'b1;
    sample(); ctrl("halt_hazard", 0, 0, 0, 1, 0);
    chk("branch_hazard.flush_cnt", hif.o_flush_cnt, 4'd2);
    chk("branch_hazard.stall_cnt", hif.o_stall_cnt, 4'd3);

    tick(); hif.i_enable = 1'b0; hif.i_branch_taken = 1'b1;
    sample(); ctrl("disabled", 0, 0, 0, 0, 0);
    chk("halt_hazard.stall_cnt", hif.o_stall_cnt, 4'd4);
    tick(); clear_inputs();
    sample(); ctrl("reenabled", 1, 1, 0, 0, 0);
    chk("disabled.stall_cnt", hif.o_stall_cnt, 4'd4);
    chk("disabled.flush_cnt", hif.o_flush_cnt, 4'd2);

    tick(); hif.i_halt_ID = 1'b1; hif.i_branch_taken = 1'b1;
    sample(); ctrl("halt_t", 0, 1, 1, 0, 0);
    for (int unsigned d = 1; d <= 3; d++) begin
      tick();
      hif.i_halt_ID       = 1'b0;
      hif.i_branch_taken  = (d == 1);
      hif.i_memRead_ID_EX = (d == 2);
      hif.i_rt_ID_EX      = 5'd6;
      hif.i_rs_IF_ID      = 5'd6;
      sample(); ctrl("drain", 0, 1, 1, 0, 0);
      if (d == 1) chk("halt.flush_cnt", hif.o_flush_cnt, 4'd2);
    end
    for (int unsigned h = 0; h <= 10; h++) begin
      tick();
      hif.i_branch_taken  = 1'b1;
      hif.i_memRead_ID_EX = 1'b1;
      hif.i_halt_ID       = h[0];
      sample(); ctrl("halted", 0, 0, 0, 0, 1);
    end
    chk("halted.stall_cnt", hif.o_stall_cnt, 4'd4);
    chk("halted.flush_cnt", hif.o_flush_cnt, 4'd2);

    tick(); rst = 1'b1;
    sample(); ctrl("reset_halted", 0, 0, 0, 0, 0);
    tick(); rst = 1'b0; clear_inputs();
    sample(); ctrl("run_after_reset", 1, 1, 0, 0, 0);
    chk("run_after_reset.stall_cnt", hif.o_stall_cnt, 4'd0);
    chk("run_after_reset.flush_cnt", hif.o_flush_cnt, 4'd0);

    tick(); hif.i_halt_ID = 1'b1;
    sample(); ctrl("halt2_t", 0, 1, 1, 0, 0);
    tick(); hif.i_halt_ID = 1'b0;
    sample(); ctrl("drain2_1", 0, 1, 1, 0, 0);
    tick(); hif.i_enable = 1'b0;
    sample(); ctrl("drain2_off1", 0, 0, 0, 0, 0);
    tick();
    sample(); ctrl("drain2_off2", 0, 0, 0, 0, 0);
    tick(); hif.i_enable = 1'b1;
    sample(); ctrl("drain2_2", 0, 1, 1, 0, 0);
    tick();
    sample(); ctrl("drain2_3", 0, 1, 1, 0, 0);
    tick();
    sample(); ctrl("halted2", 0, 0, 0, 0, 1);

    tick(); rst = 1'b1;
    tick(); rst = 1'b0; clear_inputs();
    hif.i_memRead_ID_EX = 1'b1; hif.i_rt_ID_EX = 5'd9; hif.i_rs_IF_ID = 5'd9;
    for (int unsigned i = 0; i < 20; i++) begin
      sample();
      chk("sat.bubble", hif.o_id_ex_bubble, 1'b1);
      if (i == 14) chk("sat.stall_cnt_14", hif.o_stall_cnt, 4'd14);
      if (i == 16) chk("sat.stall_cnt_16", hif.o_stall_cnt, 4'd15);
      tick();
    end
    hif.i_memRead_ID_EX = 1'b0;
    sample();
    chk("sat.stall_cnt_final", hif.o_stall_cnt, 4'd15);
    ctrl("sat_end", 1, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
